// File: rtl/syncfifo_flex_if.sv
// Handshake bundle for syncfifo_flex: write side, read side, flush and status.
// The FIFO uses the slave modport; the producer/consumer side uses master.
interface syncfifo_flex_if #(
  parameter int DSIZE = 8,
  parameter int ASIZE = 4
);
  logic             flush;
  logic             winc;
  logic [DSIZE-1:0] wdata;
  logic             wfull;
  logic             walmost_full;
  logic             rinc;
  logic [DSIZE-1:0] rdata;
  logic             rvalid;
  logic             rempty;
  logic             ralmost_empty;
  logic [ASIZE:0]   count;
  logic             overflow;
  logic             underflow;

  modport master (
    output flush, winc, wdata, rinc,
    input  wfull, walmost_full, rdata, rvalid, rempty, ralmost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  flush, winc, wdata, rinc,
    output wfull, walmost_full, rdata, rvalid, rempty, ralmost_empty,
           count, overflow, underflow
  );
endinterface

// File: rtl/syncfifo_flex.sv
// Single-clock FIFO with registered or first-word-fall-through read, programmable
// almost-full/almost-empty levels, occupancy count, sticky error flags and sync flush.
module syncfifo_flex #(
  parameter int DSIZE      = 8,
  parameter int ASIZE      = 4,
  parameter int FWFT       = 0,
  parameter int AFULL_LVL  = 2**ASIZE - 2,
  parameter int AEMPTY_LVL = 2
) (
  input logic           clk,
  input logic           rst_n,
  syncfifo_flex_if.slave fif
);
  localparam int DEPTH = 2**ASIZE;
  localparam logic [ASIZE:0] DEPTH_C  = DEPTH[ASIZE:0];
  localparam logic [ASIZE:0] AFULL_C  = AFULL_LVL[ASIZE:0];
  localparam logic [ASIZE:0] AEMPTY_C = AEMPTY_LVL[ASIZE:0];
  localparam logic [ASIZE:0] PTR_ONE  = {{ASIZE{1'b0}}, 1'b1};

  generate
    if (AFULL_LVL < 1 || AFULL_LVL > DEPTH) begin : g_bad_afull
      $error("syncfifo_flex: AFULL_LVL must be within 1..DEPTH");
    end
    if (AEMPTY_LVL < 0 || AEMPTY_LVL > DEPTH - 1) begin : g_bad_aempty
      $error("syncfifo_flex: AEMPTY_LVL must be within 0..DEPTH-1");
    end
  endgenerate

  logic [DSIZE-1:0] mem [DEPTH];
  logic [ASIZE:0]   wptr_reg, rptr_reg, count_reg, count_next;
  logic             wfull_reg, walmost_full_reg, rempty_reg, ralmost_empty_reg;
  logic             overflow_reg, underflow_reg;
  logic             wr_acc, rd_acc;

  assign wr_acc = fif.winc && !wfull_reg;
  assign rd_acc = fif.rinc && !rempty_reg;

  always_comb begin
    count_next = count_reg;
    if (wr_acc && !rd_acc)
      count_next = count_reg + PTR_ONE;
    else if (!wr_acc && rd_acc)
      count_next = count_reg - PTR_ONE;
  end

  // Reset and flush return the control state to the same empty condition.
  always_ff @(posedge clk) begin
    if (!rst_n || fif.flush) begin
      wptr_reg          <= '0;
      rptr_reg          <= '0;
      count_reg         <= '0;
      wfull_reg         <= 1'b0;
      walmost_full_reg  <= 1'b0;
      rempty_reg        <= 1'b1;
      ralmost_empty_reg <= 1'b1;
      overflow_reg      <= 1'b0;
      underflow_reg     <= 1'b0;
    end else begin
      if (wr_acc) wptr_reg <= wptr_reg + PTR_ONE;
      if (rd_acc) rptr_reg <= rptr_reg + PTR_ONE;
      count_reg         <= count_next;
      wfull_reg         <= (count_next == DEPTH_C);
      walmost_full_reg  <= (count_next >= AFULL_C);
      rempty_reg        <= (count_next == '0);
      ralmost_empty_reg <= (count_next <= AEMPTY_C);
      if (fif.winc && wfull_reg)  overflow_reg  <= 1'b1;
      if (fif.rinc && rempty_reg) underflow_reg <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc && rst_n && !fif.flush)
      mem[wptr_reg[ASIZE-1:0]] <= fif.wdata;
  end

  generate
    if (FWFT == 0) begin : g_reg_read
      logic [DSIZE-1:0] rdata_reg;
      logic             rvalid_reg;
      // Flush only drops rvalid; rdata keeps the last word that was read.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          rdata_reg  <= '0;
          rvalid_reg <= 1'b0;
        end else if (fif.flush) begin
          rvalid_reg <= 1'b0;
        end else begin
          rvalid_reg <= rd_acc;
          if (rd_acc) rdata_reg <= mem[rptr_reg[ASIZE-1:0]];
        end
      end
      assign fif.rdata  = rdata_reg;
      assign fif.rvalid = rvalid_reg;
    end else begin : g_fwft_read
      assign fif.rdata  = mem[rptr_reg[ASIZE-1:0]];
      assign fif.rvalid = !rempty_reg;
    end
  endgenerate

  assign fif.count         = count_reg;
  assign fif.wfull         = wfull_reg;
  assign fif.walmost_full  = walmost_full_reg;
  assign fif.rempty        = rempty_reg;
  assign fif.ralmost_empty = ralmost_empty_reg;
  assign fif.overflow      = overflow_reg;
  assign fif.underflow     = underflow_reg;
endmodule

// File: tb/tb_syncfifo_flex.sv
// Drives a registered-read and an FWFT instance with identical stimulus and checks both
// against a queue scoreboard of the expected FIFO contents.
module tb_syncfifo_flex;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  syncfifo_flex_if #(.DSIZE(8), .ASIZE(4)) if0 ();
  syncfifo_flex_if #(.DSIZE(8), .ASIZE(4)) if1 ();

  syncfifo_flex #(.DSIZE(8), .ASIZE(4), .FWFT(0)) u_reg  (.clk(clk), .rst_n(rst_n), .fif(if0.slave));
  syncfifo_flex #(.DSIZE(8), .ASIZE(4), .FWFT(1)) u_fwft (.clk(clk), .rst_n(rst_n), .fif(if1.slave));

  int checks = 0;
  int failures = 0;
  int txn = 0;

  logic [7:0] mq[$];
  logic       m_ovf, m_unf;
  logic [7:0] m_last0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (txn %0d)", tag, obs, exp, txn);
    end
  endtask

  task automatic drive(input logic w, input logic [7:0] d, input logic r, input logic f);
    if0.winc = w; if0.wdata = d; if0.rinc = r; if0.flush = f;
    if1.winc = w; if1.wdata = d; if1.rinc = r; if1.flush = f;
  endtask

  task automatic check_status();
    int n;
    n = mq.size();
    check("count0",   32'(if0.count), 32'(n));
    check("count1",   32'(if1.count), 32'(n));
    check("wfull0",   32'(if0.wfull), 32'(n == 16));
    check("wfull1",   32'(if1.wfull), 32'(n == 16));
    check("afull0",   32'(if0.walmost_full), 32'(n >= 14));
    check("afull1",   32'(if1.walmost_full), 32'(n >= 14));
    check("rempty0",  32'(if0.rempty), 32'(n == 0));
    check("rempty1",  32'(if1.rempty), 32'(n == 0));
    check("aempty0",  32'(if0.ralmost_empty), 32'(n <= 2));
    check("aempty1",  32'(if1.ralmost_empty), 32'(n <= 2));
    check("ovf0",     32'(if0.overflow), 32'(m_ovf));
    check("ovf1",     32'(if1.overflow), 32'(m_ovf));
    check("unf0",     32'(if0.underflow), 32'(m_unf));
    check("unf1",     32'(if1.underflow), 32'(m_unf));
    check("rvalid1",  32'(if1.rvalid), 32'(n != 0));
    if (n != 0) check("rdata1_head", 32'(if1.rdata), 32'(mq[0]));
  endtask

  task automatic step(input logic w, input logic [7:0] d, input logic r, input logic f);
    logic rd_ok, wr_ok;
    drive(w, d, r, f);
    rd_ok = 1'b0;
    if (f) begin
      mq.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      wr_ok = w && (mq.size() < 16);
      rd_ok = r && (mq.size() > 0);
      if (w && mq.size() == 16) m_ovf = 1'b1;
      if (r && mq.size() == 0)  m_unf = 1'b1;
      if (rd_ok) m_last0 = mq.pop_front();
      if (wr_ok) mq.push_back(d);
    end
    @(posedge clk); #1;
    txn++;
    $display("txn %0d w=%0b d=%02h r=%0b f=%0b count=%0d rd0=%02h rv0=%0b rd1=%02h",
             txn, w, d, r, f, if0.count, if0.rdata, if0.rvalid, if1.rdata);
    check("rvalid0", 32'(if0.rvalid), 32'(rd_ok));
    check("rdata0",  32'(if0.rdata), 32'(m_last0));
    check_status();
  endtask

  // Reset is pulsed with write and flush also asserted to show reset wins.
  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b1, 8'hEE, 1'b1, 1'b1);
    mq.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    m_last0 = 8'h00;
    @(posedge clk); #1;
    txn++;
    $display("txn %0d reset count=%0d", txn, if0.count);
    check("rst_rvalid0", 32'(if0.rvalid), 32'd0);
    check("rst_rdata0",  32'(if0.rdata), 32'd0);
    check_status();
    rst_n = 1'b1;
    drive(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    do_reset();

    // Fill to full, then full with write+read together
    for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    step(1'b1, 8'hAA, 1'b1, 1'b0);
    for (int i = 0; i < 15; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

    // Underflow, flush that ignores winc/rinc, empty+write+read
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b1, 8'h77, 1'b1, 1'b1);
    step(1'b1, 8'h33, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // Single word round trip, then FWFT head presentation
    step(1'b1, 8'h5A, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b1, 8'h11, 1'b0, 1'b0);
    step(1'b1, 8'h22, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // Pointer wrap with simultaneous traffic
    for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) step(1'b1, 8'($urandom_range(0, 255)), 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

    // Random mix
    for (int i = 0; i < 80; i++)
      step(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b0);
    for (int i = 0; i < 17; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

    // Half full, reset mid-burst, then only new data is visible
    for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
    do_reset();
    step(1'b1, 8'hC3, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
